// File: rtl/divider_array_scheduler.sv
// divider_array_scheduler: round-robin front-end sharing one combinational 16/8 divider core between requesters
module divider_array_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [16*NUM_REQ-1:0]  req_n,
   input  logic [8*NUM_REQ-1:0]   req_d,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_id,
   output logic [7:0]             rsp_q,
   output logic [7:0]             rsp_r,
   output logic                   rsp_dbz,
   output logic                   rsp_ovf,
   output logic [15:0]            div_n,
   output logic [7:0]             div_d,
   input  logic [7:0]             div_q,
   input  logic [7:0]             div_r,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
   state_t state, state_nxt;
   logic [1:0] ptr, win, idx;
   logic found, screen;
   logic [3:0] cnt;
   logic [15:0] win_n;
   logic [7:0] win_d;
   // lowest offset from the pointer wins, so scan offsets downward and let the last hit stand
   always_comb begin
      found = 1'b0;
      win = ptr;
      idx = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         idx = 2'((int'(ptr) + k) % NUM_REQ);
         if (req_valid[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
   end
   assign win_n = req_n[16*win +: 16];
   assign win_d = req_d[8*win +: 8];
   assign screen = (win_d == 8'd0) || (win_n[15:8] >= win_d);
   assign req_ready = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
   assign rsp_valid = state == RESP;
   assign busy = state != IDLE;
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE)   ? (found ? (screen ? RESP : SETTLE) : IDLE) :
                  (state == SETTLE) ? ((cnt == 4'd0) ? RESP : SETTLE) :
                                      (rsp_ready ? IDLE : RESP);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
         div_n <= '0;
         div_d <= '0;
         rsp_id <= '0;
         rsp_q <= '0;
         rsp_r <= '0;
         rsp_dbz <= 1'b0;
         rsp_ovf <= 1'b0;
      end else if (state == IDLE && found) begin
         div_n <= win_n;
         div_d <= win_d;
         rsp_id <= win;
         ptr <= 2'((int'(win) + 1) % NUM_REQ);
         cnt <= 4'(SETTLE_CYCLES - 1);
         rsp_q <= 8'hFF;
         rsp_r <= win_n[7:0];
         rsp_dbz <= win_d == 8'd0;
         rsp_ovf <= (win_d != 8'd0) && (win_n[15:8] >= win_d);
      end else if (state == SETTLE) begin
         if (cnt == 4'd0) begin
            rsp_q <= div_q;
            rsp_r <= div_r;
            rsp_dbz <= 1'b0;
            rsp_ovf <= 1'b0;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_divider_array_scheduler.sv
// tb_divider_array_scheduler: transaction-level reference model plus directed and random stimulus
module tb_divider_array_scheduler;
   localparam int N = 4;
   localparam int S = 3;
   logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b1;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [15:0] sn [N];
   logic [7:0] sd [N];
   logic [16*N-1:0] req_n;
   logic [8*N-1:0] req_d;
   logic rsp_valid, rsp_dbz, rsp_ovf, busy;
   logic [1:0] rsp_id;
   logic [7:0] rsp_q, rsp_r, div_d, div_q, div_r;
   logic [15:0] div_n;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;
   assign req_n = {sn[3], sn[2], sn[1], sn[0]};
   assign req_d = {sd[3], sd[2], sd[1], sd[0]};
   // ideal shared core
   assign div_q = (div_d == 8'd0) ? 8'h00 : 8'(div_n / {8'd0, div_d});
   assign div_r = (div_d == 8'd0) ? 8'h00 : 8'(div_n % {8'd0, div_d});

   divider_array_scheduler #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_n(req_n), .req_d(req_d), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf),
      .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: one outstanding transaction, its expected response and remaining wait
   bit m_busy = 1'b0;
   int m_wait = 0, m_ptr = 0, mw;
   logic [1:0] m_id;
   logic [7:0] m_q, m_r, m_d = '0;
   logic [15:0] m_n = '0;
   bit m_dbz, m_ovf;
   logic [3:0] er, g_last = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_rsp_fields", {12'd0, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_ovf}, 0);
         chk("rst_div", {8'd0, div_n, div_d}, 0);
         m_busy = 1'b0; m_ptr = 0; m_n = '0; m_d = '0; g_last = '0;
      end else begin
         mw = -1;
         if (!m_busy)
            for (int k = N-1; k >= 0; k--)
               if (req_valid[(m_ptr + k) % N]) mw = (m_ptr + k) % N;
         er = (mw >= 0) ? 4'(1 << mw) : 4'd0;
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_wait == 0));
         chk("div_operands", {8'd0, div_n, div_d}, {8'd0, m_n, m_d});
         if (m_busy && m_wait == 0)
            chk("rsp_fields", {12'd0, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_ovf},
                {12'd0, m_id, m_q, m_r, m_dbz, m_ovf});
         g_last = er;
         if (m_busy) begin
            if (m_wait > 0) m_wait--;
            else if (rsp_ready) m_busy = 1'b0;
         end else if (mw >= 0) begin
            m_busy = 1'b1;
            m_id = 2'(mw);
            m_n = sn[mw];
            m_d = sd[mw];
            m_ptr = (mw + 1) % N;
            m_dbz = m_d == 0;
            m_ovf = !m_dbz && (int'(m_n) / int'(m_d)) > 255;
            if (m_dbz || m_ovf) begin
               m_q = 8'hFF; m_r = m_n[7:0]; m_wait = 0;
            end else begin
               m_q = 8'(int'(m_n) / int'(m_d)); m_r = 8'(int'(m_n) % int'(m_d)); m_wait = S;
            end
         end
      end
   end

   task automatic xact(input int i, input logic [15:0] n, input logic [7:0] d, output int lat);
      int k;
      @(posedge clk); #1;
      sn[i] = n; sd[i] = d; req_valid[i] = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!req_ready[i] && k < 40);
      if (k >= 40) chk("grant_timeout", 32'(req_ready[i]), 1);
      @(posedge clk); #1 req_valid[i] = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
   endtask

   task automatic gen(input int i);
      int mode;
      mode = int'($urandom % 8);
      if (mode == 0) begin sd[i] = 8'd0; sn[i] = 16'($urandom); end
      else if (mode == 1) begin sd[i] = 8'($urandom); sn[i] = 16'($urandom); end
      else begin
         sd[i] = 8'($urandom_range(1, 255));
         sn[i] = {8'($urandom_range(0, int'(sd[i]) - 1)), 8'($urandom)};
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, k;
      int order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) begin sn[i] = '0; sd[i] = '0; end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      xact(0, 16'd1000, 8'd7, lat);
      chk("norm_latency", 32'(lat), 4);
      chk("norm_q", 32'(rsp_q), 142);
      chk("norm_r", 32'(rsp_r), 6);
      chk("norm_flags", {30'd0, rsp_dbz, rsp_ovf}, 0);
      xact(3, 16'd500, 8'd0, lat);
      chk("dbz_latency", 32'(lat), 1);
      chk("dbz_fields", {16'd0, rsp_q, rsp_r}, 32'hFFF4);
      chk("dbz_flag", {30'd0, rsp_dbz, rsp_ovf}, 2);
      xact(1, 16'h0A00, 8'd5, lat);
      chk("ovf_latency", 32'(lat), 1);
      chk("ovf_fields", {16'd0, rsp_q, rsp_r}, 32'hFF00);
      chk("ovf_flag", {30'd0, rsp_dbz, rsp_ovf}, 1);
      // reset during SETTLE
      @(posedge clk); #1 sn[1] = 16'd1000; sd[1] = 8'd7; req_valid[1] = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!req_ready[1] && k < 40);
      @(posedge clk); #1 req_valid[1] = 1'b0;
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_div", {8'd0, div_n, div_d}, 0);
      for (int i = 0; i < N; i++) begin sn[i] = 16'(i * 300 + 50); sd[i] = 8'(9 + i); end
      req_valid = '1;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      for (int g = 0; g < 5; g++) begin
         k = 0;
         do begin @(negedge clk); k++; end while (req_ready == 0 && k < 40);
         chk("rr_order", 32'(req_ready), 32'(1 << order[g]));
         @(posedge clk);
      end
      #1 req_valid = '0;
      k = 0;
      do begin @(negedge clk); k++; end while (busy && k < 40);
      // response backpressure with requester 2 pending
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      sn[1] = 16'd4321; sd[1] = 8'd99; sn[2] = 16'd777; sd[2] = 8'd200;
      req_valid[1] = 1'b1; req_valid[2] = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (req_ready == 0 && k < 40);
      chk("bp_first_grant", 32'(req_ready), 2);
      @(posedge clk); #1 req_valid[1] = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!rsp_valid && k < 40);
      repeat (10) begin
         @(negedge clk);
         chk("bp_ready_low", 32'(req_ready), 0);
         chk("bp_busy", 32'(busy), 1);
         chk("bp_hold", {rsp_valid, 13'd0, rsp_id, rsp_q, rsp_r}, {1'b1, 13'd0, 2'd1, 8'd43, 8'd64});
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_grant", 32'(req_ready), 4);
      @(posedge clk); #1 req_valid[2] = 1'b0;
      // random traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rsp_ready = ($urandom % 4) != 0;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || g_last[i]) begin
               req_valid[i] = ($urandom % 3) == 0;
               gen(i);
            end else if (($urandom % 32) == 0) req_valid[i] = 1'b0;
         end
      end
      @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1;
      repeat (30) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
